// File: rtl/pwmdac_pkg.sv
// pwmdac_pkg: shared types, constants and sample conversion for the PWM DAC feeder
package pwmdac_pkg;
    typedef enum logic {PRIME, RUN} state_t;
    localparam int SAMPLE_W_IN = 16;
    localparam int SAMPLE_W_OUT = 8;
    localparam logic [16:0] ROUND_BIAS = 17'd128;
    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam int DAC_PERIOD = 256;

    // Only positive overflow is possible, since the bias is added and never subtracted.
    function automatic logic [SAMPLE_W_OUT-1:0] sat_round_16to8(input logic [SAMPLE_W_IN-1:0] x);
        logic [16:0] s;
        s = {x[15], x} + ROUND_BIAS;
        return (s[16] != s[15]) ? SAT_POS : s[15:8];
    endfunction
endpackage

// File: rtl/pwmdac_sample_fifo.sv
// pwmdac_sample_fifo: synchronous FIFO with clear, combinational head and occupancy
module pwmdac_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/pwmdac_feeder.sv
// pwmdac_feeder: buffers 16-bit samples, converts to 8-bit and feeds the DAC pull interface
module pwmdac_feeder
    import pwmdac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int START_LEVEL = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [SAMPLE_W_IN-1:0]   src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic [SAMPLE_W_OUT-1:0]  dac_data,
    input  logic                     dac_ack,
    output logic [AW:0]              level,
    output logic                     running,
    output logic [7:0]               underrun_cnt
);
    state_t state, next_state;
    logic push, pop, empty, underrun;
    logic [SAMPLE_W_OUT-1:0] head;

    assign empty = level == '0;
    assign src_ready = level != (AW+1)'(DEPTH);
    assign push = src_valid && src_ready && !flush;
    assign pop = state == RUN && dac_ack && !empty && !flush;
    assign underrun = state == RUN && dac_ack && empty && !flush;
    assign running = state == RUN;
    assign dac_data = (running && !empty) ? head : '0;

    pwmdac_sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W_OUT)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clear(flush),
        .push(push),
        .pop(pop),
        .din(sat_round_16to8(src_data)),
        .head(head),
        .level(level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= PRIME;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) next_state = PRIME;
        else if (state == PRIME) next_state = level >= (AW+1)'(START_LEVEL) ? RUN : PRIME;
        else if (underrun) next_state = PRIME;
    end

    always_ff @(posedge clk) begin
        if (rst) underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pwmdac_feeder.sv
// tb_pwmdac_feeder: directed self-checking bench for pwmdac_feeder
module tb_pwmdac_feeder;
    import pwmdac_pkg::*;

    logic clk = 0, rst = 0, flush = 0, src_valid = 0, dac_ack = 0;
    logic [15:0] src_data = '0;
    logic src_ready, running;
    logic [7:0] dac_data, underrun_cnt;
    logic [3:0] level;
    int checks = 0, errors = 0;

    pwmdac_feeder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dac_data(dac_data), .dac_ack(dac_ack),
        .level(level), .running(running), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        src_valid = 1;
        src_data = d;
        tick();
        src_valid = 0;
    endtask

    task automatic ack();
        dac_ack = 1;
        tick();
        dac_ack = 0;
    endtask

    task automatic ack_slow();
        repeat (DAC_PERIOD - 1) tick();
        ack();
    endtask

    task automatic reset_dut();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_ready"}, src_ready, 1);
        check({tag, "_dac"}, dac_data, 0);
        check({tag, "_run"}, running, 0);
        check({tag, "_ucnt"}, underrun_cnt, 0);
    endtask

    task automatic prime_and_underrun();
        repeat (4) push(16'h0100);
        tick();
        repeat (5) ack();
    endtask

    initial begin
        logic [15:0] vec [4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFF7F};
        logic [7:0] expv [4] = '{8'h12, 8'h7F, 8'h80, 8'hFF};

        reset_dut();
        check_reset("rst0");

        foreach (vec[i]) push(vec[i]);
        check("prime_level", level, 4);
        check("prime_not_run", running, 0);
        check("prime_dac0", dac_data, 0);
        tick();
        check("run_rise", running, 1);
        check("head0", dac_data, expv[0]);
        for (int i = 1; i < 4; i++) begin
            ack_slow();
            check($sformatf("head%0d", i), dac_data, expv[i]);
        end
        ack_slow();
        check("drained_level", level, 0);
        check("drained_dac", dac_data, 0);
        check("drained_run", running, 1);
        ack_slow();
        check("ur_cnt", underrun_cnt, 1);
        check("ur_run", running, 0);
        check("ur_dac", dac_data, 0);
        ack_slow();
        ack_slow();
        check("prime_ack_ignored", underrun_cnt, 1);

        for (int i = 1; i <= 8; i++) push(16'(i) << 8);
        check("full_level", level, 8);
        check("full_ready", src_ready, 0);
        push(16'h0F00);
        check("full_reject", level, 8);
        check("full_run", running, 1);
        check("full_head", dac_data, 8'h01);
        ack();
        check("after_pop_level", level, 7);
        check("after_pop_ready", src_ready, 1);
        check("after_pop_head", dac_data, 8'h02);

        repeat (4) ack();
        check("lvl3", level, 3);
        check("lvl3_head", dac_data, 8'h06);
        src_valid = 1;
        src_data = 16'h0900;
        dac_ack = 1;
        tick();
        src_valid = 0;
        dac_ack = 0;
        check("pp_level", level, 3);
        check("pp_head", dac_data, 8'h07);
        ack();
        check("pp_head2", dac_data, 8'h08);
        ack();
        check("pp_head3", dac_data, 8'h09);
        ack();
        check("pp_empty", level, 0);
        src_valid = 1;
        src_data = 16'h0A00;
        dac_ack = 1;
        tick();
        src_valid = 0;
        dac_ack = 0;
        check("ur_push_level", level, 1);
        check("ur_push_cnt", underrun_cnt, 2);
        check("ur_push_run", running, 0);
        check("ur_push_dac", dac_data, 0);

        repeat (4) push(16'h0B00);
        check("fl_level5", level, 5);
        flush = 1;
        src_valid = 1;
        tick();
        flush = 0;
        src_valid = 0;
        check("fl_level", level, 0);
        check("fl_run", running, 0);
        check("fl_dac", dac_data, 0);
        check("fl_ucnt", underrun_cnt, 2);

        prime_and_underrun();
        check("mid_ucnt3", underrun_cnt, 3);
        repeat (6) push(16'h0C00);
        check("mid_level6", level, 6);
        reset_dut();
        check_reset("rst1");

        for (int i = 0; i < 255; i++) prime_and_underrun();
        check("sat_ff", underrun_cnt, 8'hFF);
        repeat (45) prime_and_underrun();
        check("sat_hold", underrun_cnt, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
